// File: rtl/tickdiv_pkg.sv
// Shared definitions for the multi-channel tick divider: channel state
// encoding, the per-channel tick counter width and the channel-index width
// helper.
package tickdiv_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_t;

    // Width of each per-channel tick counter field (optional feature).
    localparam int TCNT_W = 8;

    // Channel-index width: clog2 of the channel count, never below one bit.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tickdiv_channel.sv
// One tick divider channel: IDLE/RUN state, cycle counter, period and mode
// registers, registered tick/busy outputs. Optional per-channel tick counter
// is enabled by defining TICKDIV_CNT_EN.
module tickdiv_channel
    import tickdiv_pkg::*;
#(
    parameter int CNT_W          = 25,
    parameter int DEFAULT_PERIOD = 27000000,
    parameter int FAST_PERIOD    = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             fast_mode,
    input  logic             cfg_wr,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic             busy
`ifdef TICKDIV_CNT_EN
    ,
    output logic [TCNT_W-1:0] tick_count
`endif
);

    ch_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] period_reg;
    logic             oneshot_reg;
    logic             tick_reg;
    logic             busy_reg;
`ifdef TICKDIV_CNT_EN
    logic [TCNT_W-1:0] tcnt_reg;
`endif

    // Effective period; the >= wrap test below keeps the counter bounded
    // even when this shrinks mid-count.
    logic [CNT_W-1:0] eff_period;
    assign eff_period = fast_mode ? CNT_W'(FAST_PERIOD) : period_reg;

    // Channel FSM, counter, configuration and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            period_reg  <= CNT_W'(DEFAULT_PERIOD);
            oneshot_reg <= 1'b0;
            tick_reg    <= 1'b0;
            busy_reg    <= 1'b0;
`ifdef TICKDIV_CNT_EN
            tcnt_reg    <= '0;
`endif
        end else begin
            tick_reg <= 1'b0;
            if (cfg_wr) begin
                period_reg  <= cfg_period;
                oneshot_reg <= cfg_oneshot;
            end
            if (stop) begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
                cnt_reg   <= '0;
            end else if (start) begin
                state_reg <= ST_RUN;
                busy_reg  <= 1'b1;
                cnt_reg   <= '0;
`ifdef TICKDIV_CNT_EN
                tcnt_reg  <= '0;
`endif
            end else if (state_reg == ST_RUN) begin
                if (cnt_reg >= eff_period - CNT_W'(1)) begin
                    tick_reg <= 1'b1;
                    cnt_reg  <= '0;
`ifdef TICKDIV_CNT_EN
                    tcnt_reg <= tcnt_reg + TCNT_W'(1);
`endif
                    if (oneshot_reg) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign tick = tick_reg;
    assign busy = busy_reg;
`ifdef TICKDIV_CNT_EN
    assign tick_count = tcnt_reg;
`endif

endmodule

// File: rtl/tick_divider_multi.sv
// Multi-channel programmable tick-enable generator. Decodes configuration
// writes, flags rejected writes on cfg_err and instantiates one
// tickdiv_channel per channel. Define TICKDIV_CNT_EN to add the per-channel
// 8-bit tick_count output.
module tick_divider_multi
    import tickdiv_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 25,
    parameter int DEFAULT_PERIOD = 27000000,
    parameter int FAST_PERIOD    = 4,
    localparam int CH_W          = ch_width(NUM_CH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              fast_mode,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_oneshot,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] stop,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy,
    output logic              cfg_err
`ifdef TICKDIV_CNT_EN
    ,
    output logic [NUM_CH*TCNT_W-1:0] tick_count
`endif
);

    logic cfg_ok;
    logic cfg_err_reg;

    // A write is accepted only for an existing channel and a nonzero period.
    assign cfg_ok = cfg_we && (cfg_period != '0) && (32'(cfg_ch) < NUM_CH);

    // One-cycle error pulse for every rejected write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= cfg_we && !cfg_ok;
        end
    end

    assign cfg_err = cfg_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic ch_wr;
            assign ch_wr = cfg_ok && (32'(cfg_ch) == gi);

            tickdiv_channel #(
                .CNT_W          (CNT_W),
                .DEFAULT_PERIOD (DEFAULT_PERIOD),
                .FAST_PERIOD    (FAST_PERIOD)
            ) u_ch (
                .clock       (clock),
                .reset_n     (reset_n),
                .fast_mode   (fast_mode),
                .cfg_wr      (ch_wr),
                .cfg_period  (cfg_period),
                .cfg_oneshot (cfg_oneshot),
                .start       (start[gi]),
                .stop        (stop[gi]),
                .tick        (tick[gi]),
                .busy        (busy[gi])
`ifdef TICKDIV_CNT_EN
                ,
                .tick_count  (tick_count[gi*TCNT_W +: TCNT_W])
`endif
            );
        end
    endgenerate

endmodule

// File: tb/tb_tick_divider_multi.sv
// Directed self-checking bench for tick_divider_multi. Main instance uses
// NUM_CH=4, CNT_W=16, DEFAULT_PERIOD=100, FAST_PERIOD=4; a second NUM_CH=3
// instance exercises out-of-range channel rejection. Define TICKDIV_CNT_EN
// to also check tick_count.
module tb_tick_divider_multi;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        fast_mode = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [15:0] cfg_period = '0;
    logic        cfg_oneshot = 1'b0;
    logic [3:0]  start = '0;
    logic [3:0]  stop = '0;
    logic [3:0]  tick;
    logic [3:0]  busy;
    logic        cfg_err;

    logic        b_cfg_we = 1'b0;
    logic [1:0]  b_cfg_ch = '0;
    logic [15:0] b_cfg_period = '0;
    logic [2:0]  b_tick;
    logic [2:0]  b_busy;
    logic        b_cfg_err;

`ifdef TICKDIV_CNT_EN
    logic [31:0] tick_count;
    logic [23:0] b_tick_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    tick_divider_multi #(
        .NUM_CH(4), .CNT_W(16), .DEFAULT_PERIOD(100), .FAST_PERIOD(4)
    ) dut (
        .clock(clock), .reset_n(reset_n), .fast_mode(fast_mode),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
        .cfg_oneshot(cfg_oneshot), .start(start), .stop(stop),
        .tick(tick), .busy(busy), .cfg_err(cfg_err)
`ifdef TICKDIV_CNT_EN
        , .tick_count(tick_count)
`endif
    );

    tick_divider_multi #(
        .NUM_CH(3), .CNT_W(16), .DEFAULT_PERIOD(100), .FAST_PERIOD(4)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .fast_mode(1'b0),
        .cfg_we(b_cfg_we), .cfg_ch(b_cfg_ch), .cfg_period(b_cfg_period),
        .cfg_oneshot(1'b0), .start(3'b000), .stop(3'b000),
        .tick(b_tick), .busy(b_busy), .cfg_err(b_cfg_err)
`ifdef TICKDIV_CNT_EN
        , .tick_count(b_tick_count)
`endif
    );

    // Advance past the next rising edge; outputs of that edge are then stable.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        fast_mode = 1'b0; cfg_we = 1'b0; start = '0; stop = '0;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [15:0] p, input logic os);
        cfg_we = 1'b1; cfg_ch = ch; cfg_period = p; cfg_oneshot = os;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (tick !== 4'b0000) begin errors++; $display("FAIL reset_tick got=%b exp=0000", tick); end
        checks++;
        if (busy !== 4'b0000) begin errors++; $display("FAIL reset_busy got=%b exp=0000", busy); end
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
        $display("test_reset: outputs idle after reset");
    endtask

    task automatic test_periodic();
        cfg(2'd0, 16'd5, 1'b0);
        start = 4'b0001;
        step();
        start = '0;
        for (int n = 1; n <= 16; n++) begin
            step();
            checks++;
            if (tick[0] !== ((n % 5) == 0)) begin
                errors++; $display("FAIL periodic_tick edge=%0d got=%b exp=%b", n, tick[0], (n % 5) == 0);
            end
            checks++;
            if (busy[0] !== 1'b1 || tick[3:1] !== 3'b000) begin
                errors++; $display("FAIL periodic_busy_other edge=%0d busy0=%b tick31=%b exp busy0=1 tick31=000", n, busy[0], tick[3:1]);
            end
        end
        $display("test_periodic: ch0 period 5, 16 edges");
    endtask

    task automatic test_oneshot();
        cfg(2'd1, 16'd3, 1'b1);
        start = 4'b0010;
        step();
        start = '0;
        for (int n = 1; n <= 7; n++) begin
            step();
            checks++;
            if (tick[1] !== (n == 3)) begin
                errors++; $display("FAIL oneshot_tick edge=%0d got=%b exp=%b", n, tick[1], n == 3);
            end
            checks++;
            if (busy[1] !== (n < 3)) begin
                errors++; $display("FAIL oneshot_busy edge=%0d got=%b exp=%b", n, busy[1], n < 3);
            end
        end
        $display("test_oneshot: ch1 period 3 single tick");
    endtask

    task automatic test_period_change();
        stop = 4'b0001;
        step();
        stop = '0;
        cfg(2'd0, 16'd10, 1'b0);
        start = 4'b0001;
        step();
        start = '0;
        for (int n = 1; n <= 7; n++) begin
            step();
            checks++;
            if (tick[0] !== 1'b0) begin errors++; $display("FAIL shrink_pre edge=%0d got=%b exp=0", n, tick[0]); end
        end
        // counter is 7 here; shrink to 4 at edge 8 -> wrap at edge 9
        cfg(2'd0, 16'd4, 1'b0);
        checks++;
        if (tick[0] !== 1'b0) begin errors++; $display("FAIL shrink_edge8 got=%b exp=0", tick[0]); end
        for (int n = 9; n <= 17; n++) begin
            step();
            checks++;
            if (tick[0] !== (n == 9 || n == 13 || n == 17)) begin
                errors++; $display("FAIL shrink_tick edge=%0d got=%b exp=%b", n, tick[0], n == 9 || n == 13 || n == 17);
            end
        end
        $display("test_period_change: period 10 -> 4 mid-count");
    endtask

    task automatic test_fast();
        int cnt;
        do_reset();
        fast_mode = 1'b1;
        start = 4'b1111;
        step();
        start = '0;
        for (int n = 1; n <= 12; n++) begin
            step();
            checks++;
            if (tick !== (((n % 4) == 0) ? 4'b1111 : 4'b0000)) begin
                errors++; $display("FAIL fast_tick edge=%0d got=%b", n, tick);
            end
        end
        fast_mode = 1'b0;
        cnt = 0;
        for (int n = 13; n <= 111; n++) begin
            step();
            if (tick !== 4'b0000) cnt++;
        end
        checks++;
        if (cnt !== 0) begin errors++; $display("FAIL slow_quiet got=%0d tick_edges exp=0", cnt); end
        step();
        checks++;
        if (tick !== 4'b1111) begin errors++; $display("FAIL slow_tick edge=112 got=%b exp=1111", tick); end
        $display("test_fast: fast then default period 100");
    endtask

    task automatic test_cfg_err();
        do_reset();
        cfg(2'd2, 16'd3, 1'b0);
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_ok_noerr got=%b exp=0", cfg_err); end
        cfg(2'd2, 16'd0, 1'b1);
        checks++;
        if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_zero_err got=%b exp=1", cfg_err); end
        step();
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_pulse got=%b exp=0", cfg_err); end
        start = 4'b0100;
        step();
        start = '0;
        for (int n = 1; n <= 7; n++) begin
            step();
            checks++;
            if (tick[2] !== ((n % 3) == 0)) begin
                errors++; $display("FAIL cfg_kept_tick edge=%0d got=%b exp=%b", n, tick[2], (n % 3) == 0);
            end
        end
        b_cfg_we = 1'b1; b_cfg_ch = 2'd2; b_cfg_period = 16'd2;
        step();
        checks++;
        if (b_cfg_err !== 1'b0) begin errors++; $display("FAIL b_cfg_valid got=%b exp=0", b_cfg_err); end
        b_cfg_ch = 2'd3;
        step();
        b_cfg_we = 1'b0;
        checks++;
        if (b_cfg_err !== 1'b1) begin errors++; $display("FAIL b_cfg_range got=%b exp=1", b_cfg_err); end
        step();
        checks++;
        if (b_cfg_err !== 1'b0) begin errors++; $display("FAIL b_cfg_pulse got=%b exp=0", b_cfg_err); end
        $display("test_cfg_err: zero period and out-of-range channel rejected");
    endtask

    task automatic test_start_stop();
        int cnt;
        start = 4'b1000; stop = 4'b1100;
        step();
        start = '0; stop = '0;
        checks++;
        if (busy[3:2] !== 2'b00) begin errors++; $display("FAIL stop_wins_busy got=%b exp=00", busy[3:2]); end
        cnt = 0;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (tick[3:2] !== 2'b00 || busy[3:2] !== 2'b00) cnt++;
        end
        checks++;
        if (cnt !== 0) begin errors++; $display("FAIL stop_quiet got=%0d active_edges exp=0", cnt); end
        $display("test_start_stop: stop wins, channels stay idle");
    endtask

    task automatic test_async_reset();
        do_reset();
        cfg(2'd0, 16'd1, 1'b0);
        start = 4'b0001;
        step();
        start = '0;
        cfg(2'd1, 16'd0, 1'b0);
        checks++;
        if (tick[0] !== 1'b1 || busy[0] !== 1'b1 || cfg_err !== 1'b1) begin
            errors++; $display("FAIL async_pre tick=%b busy=%b err=%b exp 1 1 1", tick[0], busy[0], cfg_err);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (tick !== 4'b0000 || busy !== 4'b0000 || cfg_err !== 1'b0) begin
            errors++; $display("FAIL async_reset tick=%b busy=%b err=%b exp 0000 0000 0", tick, busy, cfg_err);
        end
        step();
        reset_n = 1'b1;
        $display("test_async_reset: outputs cleared without a clock edge");
    endtask

`ifdef TICKDIV_CNT_EN
    task automatic test_tick_count();
        do_reset();
        cfg(2'd0, 16'd1, 1'b0);
        start = 4'b0001;
        step();
        start = '0;
        for (int n = 1; n <= 257; n++) begin
            step();
            if (n == 255 || n == 256 || n == 257) begin
                checks++;
                if (tick_count[7:0] !== 8'(n)) begin
                    errors++; $display("FAIL tcnt_wrap edge=%0d got=%0d exp=%0d", n, tick_count[7:0], n % 256);
                end
            end
        end
        stop = 4'b0001;
        step();
        stop = '0;
        checks++;
        if (tick_count[7:0] !== 8'd1) begin errors++; $display("FAIL tcnt_stop got=%0d exp=1", tick_count[7:0]); end
        start = 4'b0001;
        step();
        start = '0;
        checks++;
        if (tick_count[7:0] !== 8'd0) begin errors++; $display("FAIL tcnt_start got=%0d exp=0", tick_count[7:0]); end
        $display("test_tick_count: wrap, stop hold, start clear");
    endtask
`endif

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_period_change();
        test_fast();
        test_cfg_err();
        test_start_stop();
        test_async_reset();
`ifdef TICKDIV_CNT_EN
        test_tick_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
